// File: rtl/anita3_evbuf_pkg.sv
// Shared definitions for the ANITA-3 event header buffer.
// Holds the header word map, the default header magic, the producer FSM
// state encoding and the layout of the slot/word fields in the buffer address.
// Both the producer and the read-side bookkeeping import this package.
package anita3_evbuf_pkg;

    // Header layout: 9 words per event, the last one is the XOR checksum.
    localparam int          HDR_WORDS  = 9;
    localparam logic [5:0]  W_MAGIC    = 6'd0;
    localparam logic [5:0]  W_ID_LO    = 6'd1;
    localparam logic [5:0]  W_ID_HI    = 6'd2;
    localparam logic [5:0]  W_TIME_LO  = 6'd3;
    localparam logic [5:0]  W_TIME_HI  = 6'd4;
    localparam logic [5:0]  W_PPS      = 6'd5;
    localparam logic [5:0]  W_PAT_LO   = 6'd6;
    localparam logic [5:0]  W_PAT_HI   = 6'd7;
    localparam logic [5:0]  W_CSUM     = 6'(HDR_WORDS - 1);

    localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'hE7A3;

    // Buffer address: [7:6] slot, [5:0] word index.
    localparam int SLOT_MSB = 7;
    localparam int SLOT_LSB = 6;
    localparam int WORD_MSB = 5;
    localparam int WORD_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_e;

    function automatic logic [7:0] make_addr(input logic [1:0] slot, input logic [5:0] word);
        logic [7:0] a;
        a = '0;
        a[SLOT_MSB:SLOT_LSB] = slot;
        a[WORD_MSB:WORD_LSB] = word;
        return a;
    endfunction

endpackage

// File: rtl/anita3_slot_ring.sv
// Slot rotation bookkeeping for the event header buffer.
// Keeps the write and clear slot pointers, the occupancy count (slots reserved
// or full), the full flag and a sticky error for clears with nothing to clear.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   accept_i        reserve the slot at wr_ptr_o (occupancy +1)
//   advance_i       writing of the current slot finished, move wr_ptr_o on
//   clear_i         oldest occupied slot has been read and cleared
//   wr_ptr_o        slot being (or about to be) written
//   clr_ptr_o       oldest occupied slot
//   occupancy_o     0..NUM_BUF
//   full_o          occupancy_o == NUM_BUF
//   clear_err_o     sticky: clear_i arrived with occupancy 0
module anita3_slot_ring #(
    parameter int NUM_BUF = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       accept_i,
    input  logic       advance_i,
    input  logic       clear_i,
    output logic [1:0] wr_ptr_o,
    output logic [1:0] clr_ptr_o,
    output logic [2:0] occupancy_o,
    output logic       full_o,
    output logic       clear_err_o
);

    logic [1:0] wr_ptr_q, clr_ptr_q;
    logic [2:0] occ_q;
    logic       clear_err_q;
    logic       clear_ok;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'(NUM_BUF - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign clear_ok = clear_i && (occ_q != 3'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= 2'd0;
            clr_ptr_q   <= 2'd0;
            occ_q       <= 3'd0;
            clear_err_q <= 1'b0;
        end else begin
            if (advance_i) wr_ptr_q  <= next_ptr(wr_ptr_q);
            if (clear_ok)  clr_ptr_q <= next_ptr(clr_ptr_q);
            // Reserve and release in the same cycle cancel out.
            case ({accept_i, clear_ok})
                2'b10:   occ_q <= occ_q + 3'd1;
                2'b01:   occ_q <= occ_q - 3'd1;
                default: occ_q <= occ_q;
            endcase
            if (clear_i && (occ_q == 3'd0)) clear_err_q <= 1'b1;
        end
    end

    assign wr_ptr_o    = wr_ptr_q;
    assign clr_ptr_o   = clr_ptr_q;
    assign occupancy_o = occ_q;
    assign full_o      = (occ_q == 3'(NUM_BUF));
    assign clear_err_o = clear_err_q;

endmodule

// File: rtl/anita3_event_writer.sv
// Producer side of the ANITA-3 event header buffer (33 MHz domain).
// On an accepted trigger the metadata is latched and written as nine 16-bit
// words into the next free slot, followed by a one-cycle event_done pulse.
// Ports:
//   clk33_i, rst_i     clock, synchronous active-high reset
//   trig_i             single-cycle trigger pulse
//   event_id_i, trig_time_i, pps_count_i, trig_pattern_i   metadata
//   buf_cleared_i      read side freed the oldest occupied slot
//   event_wr_addr_o/dat_o/wr_o   buffer RAM write port ([7:6] slot, [5:0] word)
//   event_done_o       slot on event_wr_addr_o[7:6] is complete
//   busy_o             a trigger this cycle would be dropped
//   occupancy_o        slots reserved or full
//   dropped_o          saturating count of dropped triggers
//   clear_err_o        sticky: clear arrived with nothing occupied
module anita3_event_writer
    import anita3_evbuf_pkg::*;
#(
    parameter int          NUM_BUF   = 4,
    parameter logic [15:0] HDR_MAGIC = HDR_MAGIC_DEFAULT
) (
    input  logic        clk33_i,
    input  logic        rst_i,
    input  logic        trig_i,
    input  logic [31:0] event_id_i,
    input  logic [31:0] trig_time_i,
    input  logic [15:0] pps_count_i,
    input  logic [31:0] trig_pattern_i,
    input  logic        buf_cleared_i,
    output logic [7:0]  event_wr_addr_o,
    output logic [15:0] event_wr_dat_o,
    output logic        event_wr_o,
    output logic        event_done_o,
    output logic        busy_o,
    output logic [2:0]  occupancy_o,
    output logic [15:0] dropped_o,
    output logic        clear_err_o
);

    wr_state_e   state_q;
    logic [5:0]  word_q;
    logic [15:0] csum_q;
    logic [31:0] id_q, time_q, pat_q;
    logic [15:0] pps_q;
    logic [7:0]  addr_q;
    logic [15:0] dat_q;
    logic        wr_q, done_q;
    logic [15:0] dropped_q;

    logic [1:0]  wr_ptr;
    logic [1:0]  unused_clr_ptr;
    logic        full;
    logic        accept, advance;
    logic [5:0]  word_d;
    logic [15:0] dat_d;

    assign busy_o  = (state_q != ST_IDLE) || full;
    assign accept  = trig_i && (state_q == ST_IDLE) && !full;
    assign advance = (state_q == ST_DONE);

    anita3_slot_ring #(.NUM_BUF(NUM_BUF)) u_ring (
        .clk_i       (clk33_i),
        .rst_i       (rst_i),
        .accept_i    (accept),
        .advance_i   (advance),
        .clear_i     (buf_cleared_i),
        .wr_ptr_o    (wr_ptr),
        .clr_ptr_o   (unused_clr_ptr),
        .occupancy_o (occupancy_o),
        .full_o      (full),
        .clear_err_o (clear_err_o)
    );

    // Next header word, built from the latched metadata. csum_q already holds
    // the XOR of every word emitted so far, so it is the checksum word itself.
    always_comb begin
        word_d = word_q + 6'd1;
        dat_d  = 16'h0000;
        case (word_d)
            W_ID_LO:   dat_d = id_q[15:0];
            W_ID_HI:   dat_d = id_q[31:16];
            W_TIME_LO: dat_d = time_q[15:0];
            W_TIME_HI: dat_d = time_q[31:16];
            W_PPS:     dat_d = pps_q;
            W_PAT_LO:  dat_d = pat_q[15:0];
            W_PAT_HI:  dat_d = pat_q[31:16];
            W_CSUM:    dat_d = csum_q;
            default:   dat_d = 16'h0000;
        endcase
    end

    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            word_q    <= 6'd0;
            csum_q    <= 16'h0000;
            id_q      <= 32'h0;
            time_q    <= 32'h0;
            pat_q     <= 32'h0;
            pps_q     <= 16'h0;
            addr_q    <= 8'h00;
            dat_q     <= 16'h0000;
            wr_q      <= 1'b0;
            done_q    <= 1'b0;
            dropped_q <= 16'h0000;
        end else begin
            if (trig_i && busy_o && (dropped_q != 16'hFFFF))
                dropped_q <= dropped_q + 16'd1;
            case (state_q)
                ST_IDLE: begin
                    addr_q <= 8'h00;
                    dat_q  <= 16'h0000;
                    wr_q   <= 1'b0;
                    done_q <= 1'b0;
                    if (accept) begin
                        id_q    <= event_id_i;
                        time_q  <= trig_time_i;
                        pps_q   <= pps_count_i;
                        pat_q   <= trig_pattern_i;
                        word_q  <= W_MAGIC;
                        csum_q  <= HDR_MAGIC;
                        addr_q  <= make_addr(wr_ptr, W_MAGIC);
                        dat_q   <= HDR_MAGIC;
                        wr_q    <= 1'b1;
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (word_q == W_CSUM) begin
                        addr_q  <= make_addr(wr_ptr, W_CSUM);
                        dat_q   <= 16'h0000;
                        wr_q    <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        word_q <= word_d;
                        csum_q <= csum_q ^ dat_d;
                        addr_q <= make_addr(wr_ptr, word_d);
                        dat_q  <= dat_d;
                        wr_q   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    addr_q  <= 8'h00;
                    dat_q   <= 16'h0000;
                    wr_q    <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    addr_q  <= 8'h00;
                    dat_q   <= 16'h0000;
                    wr_q    <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign event_wr_addr_o = addr_q;
    assign event_wr_dat_o  = dat_q;
    assign event_wr_o      = wr_q;
    assign event_done_o    = done_q;
    assign dropped_o       = dropped_q;

endmodule

// File: tb/tb_anita3_event_writer.sv
module tb_anita3_event_writer;

    typedef logic [15:0] words_t [9];

    typedef struct {
        logic [31:0] id;
        logic [31:0] tm;
        logic [15:0] pps;
        logic [31:0] pat;
        logic [1:0]  exp_slot;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trig = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] id = '0, tm = '0, pat = '0;
    logic [15:0] pps = '0;

    logic [7:0]  a4, a2;
    logic [15:0] d4, d2, dr4, dr2;
    logic        w4, w2, dn4, dn2, b4, b2, ce4, ce2;
    logic [2:0]  o4, o2;

    logic        use2 = 1'b0;
    logic [7:0]  m_addr;
    logic [15:0] m_dat, m_drop;
    logic        m_wr, m_done, m_busy, m_cerr;
    logic [2:0]  m_occ;

    int n_tests = 0;
    int n_fail  = 0;

    always #15 clk = ~clk;

    anita3_event_writer #(.NUM_BUF(4)) dut4 (
        .clk33_i(clk), .rst_i(rst), .trig_i(trig), .event_id_i(id),
        .trig_time_i(tm), .pps_count_i(pps), .trig_pattern_i(pat),
        .buf_cleared_i(clr), .event_wr_addr_o(a4), .event_wr_dat_o(d4),
        .event_wr_o(w4), .event_done_o(dn4), .busy_o(b4), .occupancy_o(o4),
        .dropped_o(dr4), .clear_err_o(ce4)
    );

    anita3_event_writer #(.NUM_BUF(2)) dut2 (
        .clk33_i(clk), .rst_i(rst), .trig_i(trig), .event_id_i(id),
        .trig_time_i(tm), .pps_count_i(pps), .trig_pattern_i(pat),
        .buf_cleared_i(clr), .event_wr_addr_o(a2), .event_wr_dat_o(d2),
        .event_wr_o(w2), .event_done_o(dn2), .busy_o(b2), .occupancy_o(o2),
        .dropped_o(dr2), .clear_err_o(ce2)
    );

    assign m_addr = use2 ? a2  : a4;
    assign m_dat  = use2 ? d2  : d4;
    assign m_wr   = use2 ? w2  : w4;
    assign m_done = use2 ? dn2 : dn4;
    assign m_busy = use2 ? b2  : b4;
    assign m_occ  = use2 ? o2  : o4;
    assign m_drop = use2 ? dr2 : dr4;
    assign m_cerr = use2 ? ce2 : ce4;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; trig = 1'b0; clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic words_t model(input ev_t e);
        words_t w;
        w[0] = 16'hE7A3;
        w[1] = e.id[15:0];
        w[2] = e.id[31:16];
        w[3] = e.tm[15:0];
        w[4] = e.tm[31:16];
        w[5] = e.pps;
        w[6] = e.pat[15:0];
        w[7] = e.pat[31:16];
        w[8] = 16'h0000;
        for (int k = 0; k < 8; k++) w[8] = w[8] ^ w[k];
        return w;
    endfunction

    // Drive one accepted trigger and check all 9 words plus the done cycle.
    // Returns in cycle T+11, when the next trigger may be applied.
    task automatic fire_event(input ev_t e, input words_t w);
        id = e.id; tm = e.tm; pps = e.pps; pat = e.pat;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int k = 0; k < 9; k++) begin
            chk("wr_strobe", 32'(m_wr), 32'd1);
            chk("wr_addr", 32'(m_addr), 32'({e.exp_slot, 6'(k)}));
            chk("wr_data", 32'(m_dat), 32'(w[k]));
            tick();
        end
        chk("done_pulse", 32'(m_done), 32'd1);
        chk("done_addr", 32'(m_addr), 32'({e.exp_slot, 6'd8}));
        chk("done_no_wr", 32'(m_wr), 32'd0);
        tick();
        chk("done_single", 32'(m_done), 32'd0);
    endtask

    ev_t    evs[5];
    words_t exp1;
    ev_t    e;

    initial begin
        // Stimulus tables.
        exp1 = '{16'hE7A3, 16'h5678, 16'h1234, 16'hBABE, 16'hCAFE,
                 16'h0042, 16'h8001, 16'h0000, 16'h53EC};
        evs[0] = '{32'h12345678, 32'hCAFEBABE, 16'h0042, 32'h0000_8001, 2'd0};
        evs[1] = '{32'h00000001, 32'h00010002, 16'h0003, 32'hFFFF_0000, 2'd1};
        evs[2] = '{32'hDEADBEEF, 32'h0F0F0F0F, 16'hFFFF, 32'h5555_AAAA, 2'd2};
        evs[3] = '{32'hA5A5_5A5A, 32'h8000_0001, 16'h1234, 32'h0000_0000, 2'd3};
        evs[4] = '{32'h0BADF00D, 32'h7654_3210, 16'h0100, 32'h1357_9BDF, 2'd0};

        // Reset state.
        do_reset();
        chk("rst_addr", 32'(m_addr), 32'd0);
        chk("rst_data", 32'(m_dat), 32'd0);
        chk("rst_wr", 32'(m_wr), 32'd0);
        chk("rst_done", 32'(m_done), 32'd0);
        chk("rst_busy", 32'(m_busy), 32'd0);
        chk("rst_occ", 32'(m_occ), 32'd0);
        chk("rst_dropped", 32'(m_drop), 32'd0);
        chk("rst_clear_err", 32'(m_cerr), 32'd0);

        // First event against hand-computed words.
        fire_event(evs[0], exp1);
        chk("occ_after_one", 32'(m_occ), 32'd1);

        // Four back-to-back events fill all slots.
        do_reset();
        for (int i = 0; i < 4; i++) fire_event(evs[i], model(evs[i]));
        chk("occ_full", 32'(m_occ), 32'd4);
        chk("busy_full", 32'(m_busy), 32'd1);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("full_no_wr", 32'(m_wr), 32'd0);
            tick();
        end
        chk("dropped_full", 32'(m_drop), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("occ_after_clear", 32'(m_occ), 32'd3);
        chk("busy_after_clear", 32'(m_busy), 32'd0);
        fire_event(evs[4], model(evs[4]));
        chk("occ_after_wrap", 32'(m_occ), 32'd4);

        // Trigger during an event is dropped; T+11 is accepted.
        do_reset();
        id = evs[2].id; tm = evs[2].tm; pps = evs[2].pps; pat = evs[2].pat;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        tick();
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("midev_dropped", 32'(m_drop), 32'd1);
        chk("midev_word3_addr", 32'(m_addr), 32'h03);
        chk("midev_word3_data", 32'(m_dat), 32'(evs[2].tm[15:0]));
        for (int i = 0; i < 7; i++) tick();
        chk("t11_not_busy", 32'(m_busy), 32'd0);
        e = evs[1];
        e.exp_slot = 2'd1;
        fire_event(e, model(e));
        chk("occ_two", 32'(m_occ), 32'd2);

        // Accept and clear together at occupancy 2.
        id = evs[3].id; tm = evs[3].tm; pps = evs[3].pps; pat = evs[3].pat;
        trig = 1'b1;
        clr = 1'b1;
        tick();
        trig = 1'b0;
        clr = 1'b0;
        chk("acc_clr_occ", 32'(m_occ), 32'd2);
        chk("acc_clr_addr", 32'(m_addr), 32'h80);
        for (int i = 0; i < 9; i++) tick();
        chk("acc_clr_done", 32'(m_done), 32'd1);
        chk("acc_clr_done_addr", 32'(m_addr), 32'h88);
        tick();
        clr = 1'b1;
        tick();
        chk("clr_occ1", 32'(m_occ), 32'd1);
        tick();
        clr = 1'b0;
        chk("clr_occ0", 32'(m_occ), 32'd0);
        chk("clear_err_before", 32'(m_cerr), 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clear_err_set", 32'(m_cerr), 32'd1);
        chk("clear_err_occ", 32'(m_occ), 32'd0);
        tick();
        chk("clear_err_sticky", 32'(m_cerr), 32'd1);

        // Reset in the middle of an event.
        do_reset();
        e = evs[3];
        e.exp_slot = 2'd1;
        fire_event(evs[0], exp1);
        id = e.id; tm = e.tm; pps = e.pps; pat = e.pat;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("midrst_word5", 32'(m_addr), 32'h45);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_wr", 32'(m_wr), 32'd0);
        chk("midrst_addr", 32'(m_addr), 32'd0);
        chk("midrst_data", 32'(m_dat), 32'd0);
        chk("midrst_occ", 32'(m_occ), 32'd0);
        chk("midrst_busy", 32'(m_busy), 32'd0);
        for (int i = 0; i < 10; i++) begin
            chk("midrst_no_done", 32'(m_done), 32'd0);
            tick();
        end
        e.exp_slot = 2'd0;
        fire_event(e, model(e));

        // Double-buffered build: slots alternate 0,1 and the third is dropped.
        use2 = 1'b1;
        do_reset();
        e = evs[1]; e.exp_slot = 2'd0;
        fire_event(e, model(e));
        e = evs[2]; e.exp_slot = 2'd1;
        fire_event(e, model(e));
        chk("nb2_occ_full", 32'(m_occ), 32'd2);
        chk("nb2_busy", 32'(m_busy), 32'd1);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("nb2_no_wr", 32'(m_wr), 32'd0);
        chk("nb2_dropped", 32'(m_drop), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("nb2_occ_clear", 32'(m_occ), 32'd1);
        e = evs[3]; e.exp_slot = 2'd0;
        fire_event(e, model(e));
        chk("nb2_occ_end", 32'(m_occ), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
